// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - payout request / coin-eject bus; COIN_EMPTY_EN adds hopper-empty flags and err
interface change_dispenser_if #(
    parameter int AMT_W = 4
);
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             coin100;
    logic             coin50;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] paid;
`ifdef COIN_EMPTY_EN
    logic             hop100_empty;
    logic             hop50_empty;
    logic             err;

    modport master (
        output req, amount, hop100_empty, hop50_empty,
        input  coin100, coin50, busy, done, paid, err
    );
    modport slave (
        input  req, amount, hop100_empty, hop50_empty,
        output coin100, coin50, busy, done, paid, err
    );
`else
    modport master (
        output req, amount,
        input  coin100, coin50, busy, done, paid
    );
    modport slave (
        input  req, amount,
        output coin100, coin50, busy, done, paid
    );
`endif
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 100/50 coin payout sequencer; optional COIN_EMPTY_EN hopper-empty handling
module change_dispenser #(
    parameter int AMT_W     = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input logic                clk,
    input logic                rst,
    change_dispenser_if.slave  bus
);
    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, FIN} state_t;

    state_t           state, state_n;
    logic [AMT_W-1:0] rem, rem_n, paid_q, paid_n;
    logic [TW-1:0]    timer, timer_n;
    logic             c100, c100_n, c50, c50_n, busy_q, busy_n, done_q, done_n;
    logic [AMT_W-1:0] src, pbase;
    logic             take100, take50;
`ifdef COIN_EMPTY_EN
    logic             err_q, err_n;
`endif

    // Coin selection shares one path for the first coin (from amount) and later coins (from rem).
    always_comb begin
        src     = (state == IDLE) ? bus.amount : rem;
        pbase   = (state == IDLE) ? '0 : paid_q;
        take100 = 1'b0;
        take50  = 1'b0;
`ifdef COIN_EMPTY_EN
        if (src >= AMT_W'(2)) begin
            take100 = !bus.hop100_empty;
            take50  = bus.hop100_empty && !bus.hop50_empty;
        end else if (src == AMT_W'(1)) begin
            take50  = !bus.hop50_empty;
        end
`else
        if (src >= AMT_W'(2)) begin
            take100 = 1'b1;
        end else if (src == AMT_W'(1)) begin
            take50  = 1'b1;
        end
`endif
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        paid_n  = paid_q;
        timer_n = timer;
        c100_n  = c100;
        c50_n   = c50;
        busy_n  = busy_q;
        done_n  = 1'b0;
`ifdef COIN_EMPTY_EN
        err_n   = 1'b0;
`endif
        case (state)
            IDLE, GAP: begin
                if ((state == IDLE && bus.req) || (state == GAP && timer == GAP_LAST)) begin
                    timer_n = '0;
                    busy_n  = 1'b1;
                    if (state == IDLE) begin
                        rem_n  = bus.amount;
                        paid_n = '0;
                    end
                    if (take100) begin
                        rem_n   = src - AMT_W'(2);
                        paid_n  = pbase + AMT_W'(2);
                        c100_n  = 1'b1;
                        state_n = PULSE;
                    end else if (take50) begin
                        rem_n   = src - AMT_W'(1);
                        paid_n  = pbase + AMT_W'(1);
                        c50_n   = 1'b1;
                        state_n = PULSE;
                    end else begin
                        // Nothing left to pay, or the needed hopper has run dry.
                        state_n = FIN;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
`ifdef COIN_EMPTY_EN
                        err_n   = (src != '0);
`endif
                    end
                end else if (state == GAP) begin
                    timer_n = timer + TW'(1);
                end
            end
            PULSE: begin
                if (timer == PULSE_LAST) begin
                    timer_n = '0;
                    c100_n  = 1'b0;
                    c50_n   = 1'b0;
                    state_n = GAP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rem    <= '0;
            paid_q <= '0;
            timer  <= '0;
            c100   <= 1'b0;
            c50    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef COIN_EMPTY_EN
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            paid_q <= paid_n;
            timer  <= timer_n;
            c100   <= c100_n;
            c50    <= c50_n;
            busy_q <= busy_n;
            done_q <= done_n;
`ifdef COIN_EMPTY_EN
            err_q  <= err_n;
`endif
        end
    end

    assign bus.coin100 = c100;
    assign bus.coin50  = c50;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.paid    = paid_q;
`ifdef COIN_EMPTY_EN
    assign bus.err     = err_q;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - table-driven payout vectors plus reset, re-request and hopper-empty sequences
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(4)) dif ();
    change_dispenser #(.AMT_W(4), .PULSE_CYC(4), .GAP_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        logic [3:0] amount;
        int         n100;
        int         n50;
        int         paid;
        int         done_cyc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle 1 is the cycle after the accepting edge; returns cycle index of done (-1 on timeout).
    task automatic payout(input logic [3:0] amt, input bit rereq,
                          output int n100, output int n50, output int done_cyc,
                          output int first_rise, output int bad_width, output int bad_busy);
        int  hi_len, lo_len, pulses;
        bit  p100, p50;
        n100 = 0; n50 = 0; done_cyc = -1; first_rise = -1;
        bad_width = 0; bad_busy = 0;
        hi_len = 0; lo_len = 0; pulses = 0; p100 = 0; p50 = 0;
        @(negedge clk);
        dif.req    = 1'b1;
        dif.amount = amt;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            dif.req = rereq && cyc >= 2 && cyc <= 8;
            if (dif.req) dif.amount = 4'd7;
            if (dif.coin100 && !p100) n100++;
            if (dif.coin50 && !p50) n50++;
            if ((dif.coin100 || dif.coin50) && !(p100 || p50)) begin
                if (first_rise < 0) first_rise = cyc;
                if (pulses > 0 && lo_len != 4) bad_width++;
                pulses++;
                hi_len = 0;
            end
            if (dif.coin100 || dif.coin50) begin
                hi_len++;
                if (!dif.busy) bad_busy++;
                if (dif.coin100 && dif.coin50) bad_width++;
            end else begin
                if (p100 || p50) begin
                    if (hi_len != 4) bad_width++;
                    lo_len = 0;
                end
                lo_len++;
            end
            p100 = dif.coin100;
            p50  = dif.coin50;
            if (dif.done) begin
                if (dif.busy) bad_busy++;
                done_cyc = cyc;
                break;
            end
        end
        dif.req = 1'b0;
    endtask

    task automatic idle_watch(input string name, input int exp_paid);
        int act;
        act = 0;
        repeat (12) begin
            @(negedge clk);
            if (dif.coin100 || dif.coin50 || dif.busy || dif.done) act++;
            if (int'(dif.paid) != exp_paid) act++;
        end
        chk(name, act, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int n100, n50, dc, fr, bw, bb;

        vecs[0] = '{4'd5,  2, 1, 5,  25};
        vecs[1] = '{4'd0,  0, 0, 0,  1};
        vecs[2] = '{4'd1,  0, 1, 1,  9};
        vecs[3] = '{4'd2,  1, 0, 2,  9};
        vecs[4] = '{4'd3,  1, 1, 3,  17};
        vecs[5] = '{4'd4,  2, 0, 4,  17};
        vecs[6] = '{4'd15, 7, 1, 15, 65};

        rst = 1'b0;
        dif.req = 1'b0;
        dif.amount = 4'd0;
`ifdef COIN_EMPTY_EN
        dif.hop100_empty = 1'b0;
        dif.hop50_empty  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {dif.coin100, dif.coin50, dif.busy, dif.done}, 0);
        chk("reset_paid", dif.paid, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            payout(vecs[i].amount, 1'b0, n100, n50, dc, fr, bw, bb);
            chk($sformatf("v%0d_n100", i), n100, vecs[i].n100);
            chk($sformatf("v%0d_n50", i), n50, vecs[i].n50);
            chk($sformatf("v%0d_paid", i), dif.paid, vecs[i].paid);
            chk($sformatf("v%0d_done_cyc", i), dc, vecs[i].done_cyc);
            if (vecs[i].amount != 0) chk($sformatf("v%0d_first_rise", i), fr, 1);
            chk($sformatf("v%0d_widths", i), bw, 0);
            chk($sformatf("v%0d_busy", i), bb, 0);
            idle_watch($sformatf("v%0d_idle_hold", i), vecs[i].paid);
        end

        // Re-request with a different amount while paying and in FIN must be ignored.
        payout(4'd2, 1'b1, n100, n50, dc, fr, bw, bb);
        chk("rereq_n100", n100, 1);
        chk("rereq_n50", n50, 0);
        chk("rereq_paid", dif.paid, 2);
        chk("rereq_done_cyc", dc, 9);
        idle_watch("rereq_idle_hold", 2);

        // Reset in the middle of the second coin100 pulse.
        @(negedge clk);
        dif.req = 1'b1;
        dif.amount = 4'd6;
        @(posedge clk);
        @(negedge clk);
        dif.req = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_coin_before", dif.coin100, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {dif.coin100, dif.coin50, dif.busy, dif.done}, 0);
        chk("midrst_paid", dif.paid, 0);
        rst = 1'b1;
        payout(4'd1, 1'b0, n100, n50, dc, fr, bw, bb);
        chk("postrst_n50", n50, 1);
        chk("postrst_n100", n100, 0);
        chk("postrst_paid", dif.paid, 1);
        chk("postrst_done_cyc", dc, 9);

`ifdef COIN_EMPTY_EN
        dif.hop100_empty = 1'b1;
        payout(4'd3, 1'b0, n100, n50, dc, fr, bw, bb);
        chk("empty100_n50", n50, 3);
        chk("empty100_n100", n100, 0);
        chk("empty100_paid", dif.paid, 3);
        chk("empty100_err", dif.err, 0);
        chk("empty100_done_cyc", dc, 25);

        dif.hop50_empty = 1'b1;
        payout(4'd4, 1'b0, n100, n50, dc, fr, bw, bb);
        chk("empty_both_coins", n100 + n50, 0);
        chk("empty_both_err", dif.err, 1);
        chk("empty_both_done_cyc", dc, 1);
        chk("empty_both_paid", dif.paid, 0);
        dif.hop100_empty = 1'b0;
        dif.hop50_empty  = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
